// File: rtl/sr_mc_control.sv
// Multi-cycle control FSM for a small RV32 subset core.
// Sequences instruction fetch, decode, execute and register write-back,
// supports a debug halt at instruction boundaries, and traps permanently
// (until reset) on any unsupported instruction.
//
// state  | code | meaning
// FETCH  | 0    | request instruction, wait for imemAck, load IR
// DECODE | 1    | classify IR; unsupported -> TRAP
// EXEC   | 2    | drive ALU controls; branches update the PC here
// WB     | 3    | write register file and advance PC by 4
// HALT   | 4    | debug halt, idle until halt drops
// TRAP   | 5    | unsupported instruction seen, idle until rst
module sr_mc_control (
   input  logic        clk,
   input  logic        rst,
   output logic        imemReq,
   input  logic        imemAck,
   input  logic [31:0] instr,
   input  logic        aluZero,
   input  logic        halt,
   output logic        irWrite,
   output logic        pcWrite,
   output logic        pcSrc,
   output logic        regWrite,
   output logic        aluSrc,
   output logic        wdSrc,
   output logic [2:0]  aluControl,
   output logic        illegal,
   output logic [2:0]  state
);

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_OR   = 3'd2;
   localparam logic [2:0] ALU_SRL  = 3'd3;
   localparam logic [2:0] ALU_SLTU = 3'd4;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_HALT   = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic        illegal_q, illegal_d;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        dec_ok;
   logic        dec_branch;
   logic        dec_bne;
   logic        dec_imm;
   logic        dec_lui;
   logic [2:0]  dec_alu;

   // Register/immediate fields are consumed by the datapath, not here.
   logic        unused_ir_bits;
   assign unused_ir_bits = ^{ir_q[24:15], ir_q[11:7]};

   assign opcode = ir_q[6:0];
   assign funct3 = ir_q[14:12];
   assign funct7 = ir_q[31:25];

   // Classify the held instruction; IR is stable from DECODE through WB.
   always_comb begin
      dec_ok     = 1'b0;
      dec_branch = 1'b0;
      dec_bne    = 1'b0;
      dec_imm    = 1'b0;
      dec_lui    = 1'b0;
      dec_alu    = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000: begin dec_ok = 1'b1; dec_alu = ALU_ADD;  end
                  3'b110: begin dec_ok = 1'b1; dec_alu = ALU_OR;   end
                  3'b101: begin dec_ok = 1'b1; dec_alu = ALU_SRL;  end
                  3'b011: begin dec_ok = 1'b1; dec_alu = ALU_SLTU; end
                  default: dec_ok = 1'b0;
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               dec_ok  = 1'b1;
               dec_alu = ALU_SUB;
            end
         end
         OP_ITYPE: begin
            if (funct3 == 3'b000) begin
               dec_ok  = 1'b1;
               dec_imm = 1'b1;
               dec_alu = ALU_ADD;
            end
         end
         OP_LUI: begin
            dec_ok  = 1'b1;
            dec_lui = 1'b1;
         end
         OP_BRANCH: begin
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
               dec_ok     = 1'b1;
               dec_branch = 1'b1;
               dec_bne    = funct3[0];
               dec_alu    = ALU_SUB;
            end
         end
         default: dec_ok = 1'b0;
      endcase
   end

   // Next-state and output decode; strobes are suppressed while rst is high
   // so a reset always wins over an ack or a pending write in that cycle.
   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      illegal_d  = illegal_q;
      imemReq    = 1'b0;
      irWrite    = 1'b0;
      pcWrite    = 1'b0;
      pcSrc      = 1'b0;
      regWrite   = 1'b0;
      aluSrc     = 1'b0;
      wdSrc      = 1'b0;
      aluControl = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            imemReq = 1'b1;
            if (imemAck) begin
               irWrite = 1'b1;
               ir_d    = instr;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (dec_ok) begin
               state_d = S_EXEC;
            end else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end
         S_EXEC: begin
            aluControl = dec_alu;
            if (dec_branch) begin
               pcWrite = 1'b1;
               pcSrc   = dec_bne ? ~aluZero : aluZero;
               state_d = halt ? S_HALT : S_FETCH;
            end else begin
               aluSrc  = dec_imm;
               wdSrc   = dec_lui;
               state_d = S_WB;
            end
         end
         S_WB: begin
            aluControl = dec_alu;
            aluSrc     = dec_imm;
            wdSrc      = dec_lui;
            regWrite   = 1'b1;
            pcWrite    = 1'b1;
            state_d    = halt ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            if (!halt) state_d = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: state_d = S_FETCH;
      endcase
      if (rst) begin
         irWrite  = 1'b0;
         pcWrite  = 1'b0;
         regWrite = 1'b0;
      end
   end

   // State, instruction register and sticky illegal flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         ir_q      <= 32'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
      end
   end

   assign illegal = illegal_q;
   assign state   = state_q;

endmodule

// File: tb/tb_sr_mc_control.sv
// Scoreboard bench for sr_mc_control: the driver pushes the expected
// strobe pattern of every instruction into a queue, and a monitor pops and
// compares whenever the DUT raises a strobe or sits in EXEC.
module tb_sr_mc_control;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_OR   = 3'd2;
   localparam logic [2:0] ALU_SRL  = 3'd3;
   localparam logic [2:0] ALU_SLTU = 3'd4;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_WB     = 3'd3;
   localparam logic [2:0] ST_HALT   = 3'd4;
   localparam logic [2:0] ST_TRAP   = 3'd5;

   logic        clk, rst, imemReq, imemAck, aluZero, halt;
   logic [31:0] instr;
   logic        irWrite, pcWrite, pcSrc, regWrite, aluSrc, wdSrc, illegal;
   logic [2:0]  aluControl, state;

   sr_mc_control dut (
      .clk(clk), .rst(rst), .imemReq(imemReq), .imemAck(imemAck),
      .instr(instr), .aluZero(aluZero), .halt(halt), .irWrite(irWrite),
      .pcWrite(pcWrite), .pcSrc(pcSrc), .regWrite(regWrite),
      .aluSrc(aluSrc), .wdSrc(wdSrc), .aluControl(aluControl),
      .illegal(illegal), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] st;
      logic       irw, pcw, rw;
      logic       full;
      logic       pcs_care, pcs;
      logic       asrc, wds;
      logic       alu_care;
      logic [2:0] aluc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Instruction set model: mask/match pairs, ALU op per instruction.
   // Index: 0 ADD,1 SUB,2 OR,3 SRL,4 SLTU,5 ADDI,6 LUI,7 BEQ,8 BNE
   logic [31:0] k_mask  [9] = '{32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
                                32'hFE00707F, 32'hFE00707F, 32'h0000707F,
                                32'h0000007F, 32'h0000707F, 32'h0000707F};
   logic [31:0] k_match [9] = '{32'h00000033, 32'h40000033, 32'h00006033,
                                32'h00005033, 32'h00003033, 32'h00000013,
                                32'h00000037, 32'h00000063, 32'h00001063};
   logic [2:0]  k_alu   [9] = '{ALU_ADD, ALU_SUB, ALU_OR, ALU_SRL, ALU_SLTU,
                                ALU_ADD, ALU_ADD, ALU_SUB, ALU_SUB};

   function automatic int classify(input logic [31:0] w);
      for (int i = 0; i < 9; i++)
         if ((w & k_mask[i]) == k_match[i]) return i;
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: any strobe or an EXEC cycle is a DUT output event.
   initial begin
      exp_t e;
      logic ok;
      forever begin
         @(negedge clk);
         if (!rst && (irWrite || pcWrite || regWrite || state == ST_EXEC)) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_output state=%0d irw=%0b pcw=%0b rw=%0b t=%0t",
                        state, irWrite, pcWrite, regWrite, $time);
            end else begin
               e  = exp_q.pop_front();
               ok = (state == e.st) && (irWrite == e.irw) &&
                    (pcWrite == e.pcw) && (regWrite == e.rw);
               if (e.full) begin
                  if (aluSrc != e.asrc || wdSrc != e.wds) ok = 1'b0;
                  if (e.pcs_care && pcSrc != e.pcs) ok = 1'b0;
                  if (e.alu_care && aluControl != e.aluc) ok = 1'b0;
               end
               if (!ok) begin
                  bad++;
                  $display("FAIL strobe actual st=%0d irw=%0b pcw=%0b rw=%0b pcs=%0b asrc=%0b wds=%0b alu=%0d required st=%0d irw=%0b pcw=%0b rw=%0b pcs=%0b asrc=%0b wds=%0b alu=%0d t=%0t",
                           state, irWrite, pcWrite, regWrite, pcSrc, aluSrc, wdSrc, aluControl,
                           e.st, e.irw, e.pcw, e.rw, e.pcs, e.asrc, e.wds, e.aluc, $time);
               end
            end
         end
      end
   end

   // Fetch phase: d wait cycles then ack; leaves the DUT in DECODE.
   task automatic do_fetch(input logic [31:0] w, input int d);
      exp_t e;
      for (int i = 0; i < d; i++) begin
         imemAck = 1'b0;
         instr   = $urandom;
         #2;
         chk("wait_imemReq", 32'(imemReq), 32'd1);
         step();
      end
      imemAck = 1'b1;
      instr   = w;
      e = '{st: ST_FETCH, irw: 1'b1, pcw: 1'b0, rw: 1'b0, full: 1'b0,
            pcs_care: 1'b0, pcs: 1'b0, asrc: 1'b0, wds: 1'b0,
            alu_care: 1'b0, aluc: ALU_ADD};
      exp_q.push_back(e);
      #2;
      chk("ack_imemReq", 32'(imemReq), 32'd1);
      step();
      imemAck = 1'b0;
      instr   = $urandom;
   endtask

   // One legal instruction from FETCH back to FETCH (through HALT if h).
   task automatic run_instr(input logic [31:0] w, input int d, input logic z, input logic h);
      exp_t e;
      int   k;
      k = classify(w);
      do_fetch(w, d);
      #2;
      chk("decode_state", 32'(state), 32'(ST_DECODE));
      step();
      aluZero = z;
      halt    = h;
      if (k >= 7) begin
         e = '{st: ST_EXEC, irw: 1'b0, pcw: 1'b1, rw: 1'b0, full: 1'b1,
               pcs_care: 1'b1, pcs: (k == 7) ? z : ~z, asrc: 1'b0, wds: 1'b0,
               alu_care: 1'b1, aluc: ALU_SUB};
         exp_q.push_back(e);
         step();
      end else begin
         e = '{st: ST_EXEC, irw: 1'b0, pcw: 1'b0, rw: 1'b0, full: 1'b1,
               pcs_care: 1'b0, pcs: 1'b0, asrc: (k == 5), wds: (k == 6),
               alu_care: (k != 6), aluc: k_alu[k]};
         exp_q.push_back(e);
         step();
         e = '{st: ST_WB, irw: 1'b0, pcw: 1'b1, rw: 1'b1, full: 1'b1,
               pcs_care: 1'b1, pcs: 1'b0, asrc: (k == 5), wds: (k == 6),
               alu_care: (k != 6), aluc: k_alu[k]};
         exp_q.push_back(e);
         step();
      end
      if (h) begin
         #2;
         chk("halt_state", 32'(state), 32'(ST_HALT));
         chk("halt_imemReq", 32'(imemReq), 32'd0);
         for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
            imemAck = 1'($urandom);
            step();
            #2;
            chk("halt_hold", 32'(state), 32'(ST_HALT));
         end
         imemAck = 1'b0;
         halt    = 1'b0;
         step();
      end
      aluZero = 1'b0;
      #2;
      chk("boundary_fetch", 32'(state), 32'(ST_FETCH));
      chk("boundary_imemReq", 32'(imemReq), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   k;
      rst = 1'b1; imemAck = 1'b0; instr = 32'd0; aluZero = 1'b0; halt = 1'b0;
      step();
      step();
      rst = 1'b0;
      #2;
      chk("reset_state", 32'(state), 32'(ST_FETCH));
      chk("reset_illegal", 32'(illegal), 32'd0);
      chk("reset_imemReq", 32'(imemReq), 32'd1);
      chk("reset_strobes", {29'd0, irWrite, pcWrite, regWrite}, 32'd0);
      step();

      // Directed: add, beq/bne with zero set, delayed ack, addi with halt.
      run_instr(32'h002081B3, 0, 1'b0, 1'b0);
      run_instr(32'h00000063, 0, 1'b1, 1'b0);
      run_instr(32'h00001063, 0, 1'b1, 1'b0);
      run_instr(32'h002081B3, 3, 1'b0, 1'b0);
      run_instr(32'h00500093, 0, 1'b0, 1'b1);
      run_instr(32'h00001063, 1, 1'b0, 1'b1);

      // Randomized legal instructions.
      for (int n = 0; n < 60; n++) begin
         k = int'($urandom_range(0, 8));
         run_instr(k_match[k] | ($urandom & ~k_mask[k]),
                   int'($urandom_range(0, 3)), 1'($urandom),
                   ($urandom_range(0, 5) == 0));
      end

      // Reset in WB of an add aborts the write.
      do_fetch(32'h002081B3, 0);
      step();
      e = '{st: ST_EXEC, irw: 1'b0, pcw: 1'b0, rw: 1'b0, full: 1'b1,
            pcs_care: 1'b0, pcs: 1'b0, asrc: 1'b0, wds: 1'b0,
            alu_care: 1'b1, aluc: ALU_ADD};
      exp_q.push_back(e);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #2;
      chk("wb_reset_state", 32'(state), 32'(ST_FETCH));
      chk("wb_reset_writes", {30'd0, regWrite, pcWrite}, 32'd0);
      step();

      // Reset wins over an ack in the same cycle.
      rst = 1'b1; imemAck = 1'b1; instr = 32'h002081B3;
      step();
      rst = 1'b0; imemAck = 1'b0;
      #2;
      chk("rst_vs_ack_state", 32'(state), 32'(ST_FETCH));
      step();

      // Unsupported instruction traps until reset.
      do_fetch(32'hFFFFFFFF, 0);
      #2;
      chk("trap_decode", 32'(state), 32'(ST_DECODE));
      step();
      #2;
      chk("trap_enter", 32'(state), 32'(ST_TRAP));
      for (int i = 0; i < 22; i++) begin
         imemAck = 1'($urandom);
         halt    = 1'($urandom);
         step();
         #2;
         chk("trap_state", 32'(state), 32'(ST_TRAP));
         chk("trap_illegal", 32'(illegal), 32'd1);
         chk("trap_imemReq", 32'(imemReq), 32'd0);
      end
      halt = 1'b0;
      imemAck = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      imemAck = 1'b0;
      #2;
      chk("trap_reset_state", 32'(state), 32'(ST_FETCH));
      chk("trap_reset_illegal", 32'(illegal), 32'd0);
      step();

      run_instr(32'h40208133, 2, 1'b0, 1'b0);
      step();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
